jump_predict_unit: RTL and testbench
====================================

# jump_predict_unit

Second-generation jump control unit for the RISC-V core. It keeps the JAL/JALR operand and writeback mux selects, and adds a parametrised branch target buffer (BTB) with 2-bit saturating counters. It also adds mispredict detection and a registered flush/redirect sequencer. It sits between the fetch stage, which looks up predictions, and the execute stage, which resolves them.

## Interface
- XLEN, 32, PC/target width.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2. IDX_W = log2(BTB_ENTRIES).
- FLUSH_CYCLES, 2, cycles JPU_Flush stays high per mispredict; ≥1.
- PREDICT_EN, 1, 0 = static not-taken mode: BTB is never read or written.

Ports:
- JPU_CLOCK_50  in  1  single clock, rising edge.
- JPU_RESET_InHigh  in  1  reset, synchronous, active-high.
- JPU_Fetch_Pc  in  XLEN  fetch PC.
- JPU_Pred_Taken  out  1  fetch prediction, combinational.
- JPU_Pred_Target  out  XLEN  predicted target, combinational.
- JPU_Ex_Valid  in  1  execute-stage instruction valid.
- JPU_Ex_Pc  in  XLEN  execute-stage PC.
- JPU_Ex_Is_Jump  in  1  JAL or JALR.
- JPU_Ex_Is_Branch  in  1  conditional branch.
- JPU_Ex_Opcode_b3  in  1  opcode bit 3: 1 = JAL, 0 = JALR.
- JPU_Ex_Taken  in  1  branch comparator result.
- JPU_Ex_Target  in  XLEN  resolved target.
- JPU_Ex_Pred_Taken  in  1  prediction carried down the pipeline.
- JPU_Ex_Pred_Target  in  XLEN  predicted target carried down the pipeline.
- JPU_Mux_b_sel  out  1  Ex_Is_Jump & ~Ex_Opcode_b3 (JALR uses rs1); combinational.
- JPU_Mux_c_sel  out  1  Ex_Is_Jump (writeback PC+4); combinational.
- JPU_Flush  out  1  registered flush of wrong-path stages.
- JPU_Redirect_Pc  out  XLEN  registered redirect PC, valid while JPU_Flush = 1.

## Operation
- **Entry format:** valid, tag = PC[XLEN-1:IDX_W+2], target[XLEN], ctr[2]. Index = PC[IDX_W+1:2].
- **Lookup:** Pred_Taken = PREDICT_EN & valid & tag match & ctr[1]. Pred_Target = entry target, or Fetch_Pc+4 when not predicting taken.
- **Resolve:** a resolve occurs when Ex_Valid & (Is_Jump | Is_Branch) & state == IDLE.
  - Actual_taken = Is_Jump | Ex_Taken.
  - Mispredict = Actual_taken ≠ Ex_Pred_Taken, or (Actual_taken & Ex_Pred_Target ≠ Ex_Target).
  - JALR is always resolved by comparison and is never allocated.
- **BTB update (PREDICT_EN = 1):**
  - Branch hit: ctr saturating +1 if taken, −1 if not. If taken, the target is rewritten.
  - Branch miss, taken: allocate the entry with ctr = 2'b10.
  - Branch miss, not taken: no write.
  - JAL: allocate or overwrite the entry with ctr = 2'b11.
- **FSM:**
  - IDLE to FLUSH on a resolve with mispredict. The flush counter is loaded with FLUSH_CYCLES−1, and Redirect_Pc is latched as Actual_taken ? Ex_Target : Ex_Pc+4.
  - FLUSH counts down and returns to IDLE after the cycle in which the counter is 0.
  - In FLUSH, Ex_Valid is ignored (wrong path): no BTB writes and no new redirect.
- Mux selects ignore the FSM state and are driven purely from the Ex inputs.

## Timing
- Lookup has 0-cycle latency; it is a combinational read of flops.
- A BTB write is visible on the cycle after the resolve edge.
- A same-cycle lookup and update of the same index returns the old (pre-update) entry.
- Flush latency: JPU_Flush rises on the edge after the mispredicting resolve. It stays high exactly FLUSH_CYCLES cycles. Redirect_Pc is stable throughout.
- **Reset values:**
  - All valid bits 0; all ctr = 2'b01; targets are don't-care.
  - State IDLE, JPU_Flush = 0, Redirect_Pc = 0.
- **Reset mid-flush:** Flush drops on the next edge and the BTB is invalidated.
- Reset has priority over a simultaneous resolve.
- **Counter arithmetic:** ctr saturates at 2'b00 and 2'b11 and never wraps.
- **PC arithmetic:** PC+4 is modulo 2^XLEN, so 0xFFFFFFFC+4 = 0.
- **PREDICT_EN = 0:** Pred_Taken is always 0. Every taken branch or jump flushes.

## Structure
- Package jpu_pkg holds the ctr encodings (SNT = 00, WNT = 01, WT = 10, ST = 11), the FSM state enum (IDLE, FLUSH), and the ctr_next saturating function.
- Sub-module jpu_btb holds the entry array with a combinational read port and a synchronous write port. The top level keeps the resolve logic, FSM, and mux selects.

## Test plan
- **Reset:** apply reset, then fetch any PC -> Pred_Taken = 0, Flush = 0, Redirect_Pc = 0.
- **JAL learning:** resolve JAL at PC 0x100 with target 0x200 and Pred_Taken = 0 -> Flush high for 2 cycles with Redirect 0x200. A later fetch of 0x100 gives Pred_Taken = 1 and Pred_Target = 0x200. Mux_b_sel = 0 and Mux_c_sel = 1 during the resolve.
- **JALR:** resolve JALR with Ex_Target 0x340 and Pred_Target 0x344 -> Mux_b_sel = 1, Flush with Redirect 0x340, no BTB entry allocated.
- **Branch hysteresis:** a branch at 0x80 is taken, taken, not-taken -> ctr goes 10, 11, 10. Prediction stays taken. The not-taken resolve flushes with Redirect 0x84.
- **Wrong-path suppression:** a second mispredicting resolve during FLUSH -> ignored. Flush width stays FLUSH_CYCLES and the BTB is unchanged.
- **Boundaries:** assert reset during FLUSH -> Flush = 0 next cycle and the BTB is cleared. Resolve a taken branch at 0xFFFFFFFC that was predicted taken with the wrong target -> Redirect = Ex_Target. If the branch is not taken instead -> Redirect = 0x0.

Source files
------------

// File: rtl/jpu_pkg.sv
// Shared types for the jump predict unit: counter encodings, FSM states and
// the saturating counter update.
package jpu_pkg;

    // 2-bit saturating predictor counter; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } ctr_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StFlush = 1'b1
    } state_e;

    // Step the counter toward the observed outcome, holding at either end
    function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
        ctr_e res;
        unique case (ctr)
            CtrSnt:  res = taken ? CtrWnt : CtrSnt;
            CtrWnt:  res = taken ? CtrWt  : CtrSnt;
            CtrWt:   res = taken ? CtrSt  : CtrWnt;
            CtrSt:   res = taken ? CtrSt  : CtrWt;
            default: res = CtrWnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/jpu_btb.sv
// Direct-mapped branch target buffer: two combinational read ports (fetch
// lookup and execute-stage update lookup) and one synchronous write port.
module jpu_btb
    import jpu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES),
    parameter int unsigned TAG_W   = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output ctr_e             rd_ctr,
    output logic [XLEN-1:0]  rd_target,
    input  logic [IDX_W-1:0] up_idx,
    input  logic [TAG_W-1:0] up_tag,
    output logic             up_hit,
    output ctr_e             up_ctr,
    input  logic             wr_en,
    input  logic             wr_target_en,
    input  ctr_e             wr_ctr,
    input  logic [XLEN-1:0]  wr_target
);

    logic            valid_q  [ENTRIES];
    ctr_e            ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_ctr    = ctr_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr    = ctr_q[up_idx];

    // Valid and counter state: cleared by reset, written on update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CtrWnt;
            end
        end else if (wr_en) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= wr_ctr;
        end
    end

    // Tag and target payload; meaningless while invalid so never reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_q[up_idx] <= up_tag;
            if (wr_target_en) begin
                target_q[up_idx] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/jump_predict_unit.sv
// Jump control unit: JAL/JALR mux selects, BTB-based prediction, mispredict
// detection and a registered flush/redirect sequencer.
module jump_predict_unit
    import jpu_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BTB_ENTRIES  = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          PREDICT_EN   = 1'b1
) (
    input  logic            JPU_CLOCK_50,
    input  logic            JPU_RESET_InHigh,
    input  logic [XLEN-1:0] JPU_Fetch_Pc,
    output logic            JPU_Pred_Taken,
    output logic [XLEN-1:0] JPU_Pred_Target,
    input  logic            JPU_Ex_Valid,
    input  logic [XLEN-1:0] JPU_Ex_Pc,
    input  logic            JPU_Ex_Is_Jump,
    input  logic            JPU_Ex_Is_Branch,
    input  logic            JPU_Ex_Opcode_b3,
    input  logic            JPU_Ex_Taken,
    input  logic [XLEN-1:0] JPU_Ex_Target,
    input  logic            JPU_Ex_Pred_Taken,
    input  logic [XLEN-1:0] JPU_Ex_Pred_Target,
    output logic            JPU_Mux_b_sel,
    output logic            JPU_Mux_c_sel,
    output logic            JPU_Flush,
    output logic [XLEN-1:0] JPU_Redirect_Pc
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e           state;
    logic [CNT_W-1:0] flush_cnt;

    logic             rd_hit;
    ctr_e             rd_ctr;
    logic [XLEN-1:0]  rd_target;
    logic             up_hit;
    ctr_e             up_ctr;
    logic             wr_en;
    logic             wr_target_en;
    ctr_e             wr_ctr;

    logic resolve;
    logic actual_taken;
    logic mispredict;
    logic is_jal;

    jpu_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk          (JPU_CLOCK_50),
        .rst          (JPU_RESET_InHigh),
        .rd_idx       (JPU_Fetch_Pc[IDX_W+1:2]),
        .rd_tag       (JPU_Fetch_Pc[XLEN-1:IDX_W+2]),
        .rd_hit       (rd_hit),
        .rd_ctr       (rd_ctr),
        .rd_target    (rd_target),
        .up_idx       (JPU_Ex_Pc[IDX_W+1:2]),
        .up_tag       (JPU_Ex_Pc[XLEN-1:IDX_W+2]),
        .up_hit       (up_hit),
        .up_ctr       (up_ctr),
        .wr_en        (wr_en),
        .wr_target_en (wr_target_en),
        .wr_ctr       (wr_ctr),
        .wr_target    (JPU_Ex_Target)
    );

    assign JPU_Pred_Taken  = PREDICT_EN && rd_hit && rd_ctr[1];
    assign JPU_Pred_Target = JPU_Pred_Taken ? rd_target : JPU_Fetch_Pc + XLEN'(4);

    assign JPU_Mux_b_sel = JPU_Ex_Is_Jump & ~JPU_Ex_Opcode_b3;
    assign JPU_Mux_c_sel = JPU_Ex_Is_Jump;

    // Wrong-path instructions arrive while flushing, so only resolve in idle
    assign resolve      = JPU_Ex_Valid && (JPU_Ex_Is_Jump || JPU_Ex_Is_Branch) &&
                          (state == StIdle);
    assign actual_taken = JPU_Ex_Is_Jump | JPU_Ex_Taken;
    assign mispredict   = (actual_taken != JPU_Ex_Pred_Taken) ||
                          (actual_taken && (JPU_Ex_Pred_Target != JPU_Ex_Target));
    assign is_jal       = JPU_Ex_Is_Jump & JPU_Ex_Opcode_b3;

    // BTB update decision; JALR targets are data dependent so never cached
    always_comb begin
        wr_en        = 1'b0;
        wr_target_en = 1'b0;
        wr_ctr       = CtrWt;
        if (PREDICT_EN && resolve) begin
            if (is_jal) begin
                wr_en        = 1'b1;
                wr_target_en = 1'b1;
                wr_ctr       = CtrSt;
            end else if (!JPU_Ex_Is_Jump && JPU_Ex_Is_Branch) begin
                if (up_hit) begin
                    wr_en        = 1'b1;
                    wr_target_en = JPU_Ex_Taken;
                    wr_ctr       = ctr_next(up_ctr, JPU_Ex_Taken);
                end else if (JPU_Ex_Taken) begin
                    wr_en        = 1'b1;
                    wr_target_en = 1'b1;
                    wr_ctr       = CtrWt;
                end
            end
        end
    end

    // Flush/redirect sequencer with registered outputs
    always_ff @(posedge JPU_CLOCK_50) begin
        if (JPU_RESET_InHigh) begin
            state           <= StIdle;
            flush_cnt       <= '0;
            JPU_Flush       <= 1'b0;
            JPU_Redirect_Pc <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (resolve && mispredict) begin
                        state           <= StFlush;
                        JPU_Flush       <= 1'b1;
                        flush_cnt       <= CNT_W'(FLUSH_CYCLES - 1);
                        JPU_Redirect_Pc <= actual_taken ? JPU_Ex_Target
                                                        : JPU_Ex_Pc + XLEN'(4);
                    end
                end
                StFlush: begin
                    if (flush_cnt == '0) begin
                        state     <= StIdle;
                        JPU_Flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    JPU_Flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_predict_unit.sv
// Directed bench for jump_predict_unit with hand-computed expectations.
module tb_jump_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_jump;
    logic        ex_is_branch;
    logic        ex_b3;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mux_b_sel;
    logic        mux_c_sel;
    logic        flush;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    jump_predict_unit #(
        .XLEN         (32),
        .BTB_ENTRIES  (16),
        .FLUSH_CYCLES (2),
        .PREDICT_EN   (1'b1)
    ) dut (
        .JPU_CLOCK_50       (clk),
        .JPU_RESET_InHigh   (rst),
        .JPU_Fetch_Pc       (fetch_pc),
        .JPU_Pred_Taken     (pred_taken),
        .JPU_Pred_Target    (pred_target),
        .JPU_Ex_Valid       (ex_valid),
        .JPU_Ex_Pc          (ex_pc),
        .JPU_Ex_Is_Jump     (ex_is_jump),
        .JPU_Ex_Is_Branch   (ex_is_branch),
        .JPU_Ex_Opcode_b3   (ex_b3),
        .JPU_Ex_Taken       (ex_taken),
        .JPU_Ex_Target      (ex_target),
        .JPU_Ex_Pred_Taken  (ex_pred_taken),
        .JPU_Ex_Pred_Target (ex_pred_target),
        .JPU_Mux_b_sel      (mux_b_sel),
        .JPU_Mux_c_sel      (mux_c_sel),
        .JPU_Flush          (flush),
        .JPU_Redirect_Pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        fetch_pc = pc;
        #1;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic jump, input logic branch,
                          input logic b3, input logic taken, input logic [31:0] target,
                          input logic ptaken, input logic [31:0] ptarget);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_is_jump     = jump;
        ex_is_branch   = branch;
        ex_b3          = b3;
        ex_taken       = taken;
        ex_target      = target;
        ex_pred_taken  = ptaken;
        ex_pred_target = ptarget;
        #1;
    endtask

    task automatic clr_ex();
        ex_valid     = 1'b0;
        ex_is_jump   = 1'b0;
        ex_is_branch = 1'b0;
        ex_taken     = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fetch_pc = 32'h0;
        ex_valid = 1'b0; ex_pc = 32'h0; ex_is_jump = 1'b0; ex_is_branch = 1'b0;
        ex_b3 = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
        ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        step(); step();
        rst = 1'b0;

        // Reset state
        lookup(32'h100);
        check("reset_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("reset_pred_target", pred_target, 32'h104);
        check("reset_flush", {31'b0, flush}, 32'd0);
        check("reset_redirect", redirect_pc, 32'h0);

        // JAL learning: 0x100 -> 0x200, unpredicted
        set_ex(32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h104);
        check("jal_mux_b", {31'b0, mux_b_sel}, 32'd0);
        check("jal_mux_c", {31'b0, mux_c_sel}, 32'd1);
        step();
        clr_ex();
        check("jal_flush_c1", {31'b0, flush}, 32'd1);
        check("jal_redirect", redirect_pc, 32'h200);
        lookup(32'h100);
        check("jal_pred_taken", {31'b0, pred_taken}, 32'd1);
        check("jal_pred_target", pred_target, 32'h200);
        step();
        check("jal_flush_c2", {31'b0, flush}, 32'd1);
        step();
        check("jal_flush_done", {31'b0, flush}, 32'd0);

        // JALR: wrong predicted target, never allocated
        set_ex(32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 32'h340, 1'b1, 32'h344);
        check("jalr_mux_b", {31'b0, mux_b_sel}, 32'd1);
        step();
        clr_ex();
        check("jalr_flush", {31'b0, flush}, 32'd1);
        check("jalr_redirect", redirect_pc, 32'h340);
        lookup(32'h300);
        check("jalr_no_alloc", {31'b0, pred_taken}, 32'd0);
        check("jalr_fallthru_tgt", pred_target, 32'h304);
        step(); step();
        check("jalr_flush_done", {31'b0, flush}, 32'd0);

        // Branch hysteresis at 0x80 (same index as 0x100, different tag)
        lookup(32'h80);
        check("br_initial_miss", {31'b0, pred_taken}, 32'd0);
        set_ex(32'h80, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h84);
        step();
        clr_ex();
        check("br1_flush", {31'b0, flush}, 32'd1);
        check("br1_redirect", redirect_pc, 32'h40);
        step(); step();
        lookup(32'h80);
        check("br1_pred_taken", {31'b0, pred_taken}, 32'd1);
        check("br1_pred_target", pred_target, 32'h40);
        set_ex(32'h80, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40);
        step();
        clr_ex();
        check("br2_no_flush", {31'b0, flush}, 32'd0);
        set_ex(32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40);
        step();
        clr_ex();
        check("br3_flush", {31'b0, flush}, 32'd1);
        check("br3_redirect", redirect_pc, 32'h84);
        lookup(32'h80);
        check("br3_still_taken", {31'b0, pred_taken}, 32'd1);
        step(); step();
        // Counter was 10 after br3, so one more not-taken drops it to 01
        set_ex(32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40);
        step();
        clr_ex();
        check("br4_flush", {31'b0, flush}, 32'd1);
        lookup(32'h80);
        check("br4_not_taken", {31'b0, pred_taken}, 32'd0);
        check("br4_fallthru_tgt", pred_target, 32'h84);
        step(); step();

        // Wrong-path suppression during FLUSH
        set_ex(32'h144, 1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 1'b0, 32'h148);
        step();
        set_ex(32'h188, 1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 32'h18c);
        check("wp_flush_c1", {31'b0, flush}, 32'd1);
        check("wp_redirect_c1", redirect_pc, 32'h500);
        step();
        check("wp_flush_c2", {31'b0, flush}, 32'd1);
        check("wp_redirect_c2", redirect_pc, 32'h500);
        step();
        clr_ex();
        check("wp_flush_width", {31'b0, flush}, 32'd0);
        check("wp_redirect_held", redirect_pc, 32'h500);
        lookup(32'h188);
        check("wp_no_alloc", {31'b0, pred_taken}, 32'd0);
        lookup(32'h144);
        check("wp_jal_learned", {31'b0, pred_taken}, 32'd1);

        // Reset mid-flush, with a resolve still presented at the reset edge
        set_ex(32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 32'h700, 1'b0, 32'h204);
        step();
        check("rmf_flush", {31'b0, flush}, 32'd1);
        check("rmf_redirect", redirect_pc, 32'h700);
        rst = 1'b1;
        step();
        check("rmf_flush_drop", {31'b0, flush}, 32'd0);
        check("rmf_redirect_clr", redirect_pc, 32'h0);
        rst = 1'b0;
        clr_ex();
        lookup(32'h200);
        check("rmf_btb_clr_200", {31'b0, pred_taken}, 32'd0);
        lookup(32'h144);
        check("rmf_btb_clr_144", {31'b0, pred_taken}, 32'd0);
        step();
        check("rmf_flush_idle", {31'b0, flush}, 32'd0);

        // PC wrap boundary at 0xFFFFFFFC
        lookup(32'hFFFF_FFFC);
        check("wrap_fallthru_tgt", pred_target, 32'h0);
        set_ex(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h10);
        step();
        clr_ex();
        check("wrap_tgt_flush", {31'b0, flush}, 32'd1);
        check("wrap_tgt_redirect", redirect_pc, 32'h20);
        step(); step();
        set_ex(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20);
        step();
        clr_ex();
        check("wrap_nt_flush", {31'b0, flush}, 32'd1);
        check("wrap_nt_redirect", redirect_pc, 32'h0);
        step(); step();
        check("wrap_flush_done", {31'b0, flush}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
